// File: rtl/code_seq_gen_if.sv
// Command/code bus between the command logic (master) and code_seq_gen (slave).
interface code_seq_gen_if;
    logic       start;
    logic [2:0] target;
    logic [1:0] term;
    logic [7:0] code_out;
    logic       code_valid;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] pos;

    modport master (
        output start, target, term,
        input  code_out, code_valid, busy, done, err, pos
    );

    modport slave (
        input  start, target, term,
        output code_out, code_valid, busy, done, err, pos
    );
endinterface

// File: rtl/code_seq_gen.sv
// Generates the legal code stream that walks the position-code decoder from its
// tracked position to a requested target, optionally followed by a terminator.
module code_seq_gen #(
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    code_seq_gen_if.slave  bus
);

    localparam int unsigned HOLD_W = 4;

    localparam logic [7:0] C1        = 8'h90;
    localparam logic [7:0] C2        = 8'hA4;
    localparam logic [7:0] C3        = 8'h82;
    localparam logic [7:0] C4        = 8'hC7;
    localparam logic [7:0] C5        = 8'hBA;
    localparam logic [7:0] C_ACT     = 8'h9E;
    localparam logic [7:0] C_HOUR    = 8'h8D;
    localparam logic [7:0] IDLE_CODE = 8'hFF;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STEP_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_TERM,
        S_FIN
    } state_t;

    state_t              state_q,  state_d;
    logic [2:0]          tgt_q,    tgt_d;
    logic [1:0]          term_q,   term_d;
    logic [2:0]          pos_q,    pos_d;
    logic [HOLD_W-1:0]   hold_q,   hold_d;
    logic [7:0]          code_q,   code_d;
    logic                valid_q,  valid_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                err_q,    err_d;

    logic                req_bad_c;
    logic [2:0]          next_pos_c;
    logic [HOLD_W-1:0]   hold_inc_c;

    function automatic logic [7:0] pos_code(input logic [2:0] p);
        case (p)
            3'd1:    pos_code = C1;
            3'd2:    pos_code = C2;
            3'd3:    pos_code = C3;
            3'd4:    pos_code = C4;
            3'd5:    pos_code = C5;
            default: pos_code = IDLE_CODE;
        endcase
    endfunction

    function automatic logic [7:0] term_code(input logic [1:0] t);
        term_code = (t == 2'd1) ? C_ACT : C_HOUR;
    endfunction

    // Request legality and next decoder position (direct jump from home, else one step).
    always_comb begin
        req_bad_c = (bus.target == 3'd0) || (bus.target > 3'd5) || (bus.term == 2'd3)
                 || ((bus.term == 2'd1) && (bus.target > 3'd3))
                 || ((bus.term == 2'd2) && (bus.target < 3'd4));

        if (pos_q == 3'd0)       next_pos_c = tgt_q;
        else if (pos_q < tgt_q)  next_pos_c = pos_q + 3'd1;
        else if (pos_q > tgt_q)  next_pos_c = pos_q - 3'd1;
        else                     next_pos_c = tgt_q;

        hold_inc_c = hold_q + HOLD_ONE;
    end

    // Next-state and registered-output computation; outputs appear one cycle later.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        term_d  = term_q;
        pos_d   = pos_q;
        hold_d  = hold_q;
        code_d  = IDLE_CODE;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    if (req_bad_c) begin
                        err_d = 1'b1;
                    end else begin
                        tgt_d   = bus.target;
                        term_d  = bus.term;
                        busy_d  = 1'b1;
                        hold_d  = '0;
                        state_d = S_STEP;
                    end
                end
            end

            S_STEP: begin
                if (hold_q != HOLD_LAST) begin
                    // Still holding the current position code.
                    code_d  = pos_code(next_pos_c);
                    valid_d = 1'b1;
                    hold_d  = hold_inc_c;
                    if (hold_inc_c == HOLD_LAST) pos_d = next_pos_c;
                end else if (pos_q != tgt_q) begin
                    // Previous code finished short of target: start the next one with no gap.
                    code_d  = pos_code(next_pos_c);
                    valid_d = 1'b1;
                    hold_d  = HOLD_ONE;
                    if (HOLD_ONE == HOLD_LAST) pos_d = next_pos_c;
                end else if (term_q != 2'd0) begin
                    // Terminator leaves the decoder stuck until reset, so position goes unknown.
                    state_d = S_TERM;
                    code_d  = term_code(term_q);
                    valid_d = 1'b1;
                    hold_d  = HOLD_ONE;
                    if (HOLD_ONE == HOLD_LAST) pos_d = 3'd0;
                end else begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hold_d  = '0;
                end
            end

            S_TERM: begin
                if (hold_q != HOLD_LAST) begin
                    code_d  = term_code(term_q);
                    valid_d = 1'b1;
                    hold_d  = hold_inc_c;
                    if (hold_inc_c == HOLD_LAST) pos_d = 3'd0;
                end else begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hold_d  = '0;
                end
            end

            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tgt_q   <= 3'd0;
            term_q  <= 2'd0;
            pos_q   <= 3'd0;
            hold_q  <= '0;
            code_q  <= IDLE_CODE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            term_q  <= term_d;
            pos_q   <= pos_d;
            hold_q  <= hold_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.code_out   = code_q;
    assign bus.code_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.pos        = pos_q;

endmodule

// File: tb/tb_code_seq_gen.sv
// Directed bench for code_seq_gen: one instance with single-cycle codes and one
// holding each code for three cycles.
module tb_code_seq_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    code_seq_gen_if bus1 ();
    code_seq_gen_if bus3 ();

    code_seq_gen #(.STEP_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    code_seq_gen #(.STEP_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct packed {
        logic [7:0] code;
        logic       valid;
        logic       busy;
        logic       done;
        logic       err;
        logic [2:0] pos;
    } obs_t;

    typedef struct {
        int         sel;
        logic [2:0] tgt;
        logic [1:0] trm;
        bit         exp_err;
        int         n;
        logic [7:0] c [6];
        logic [2:0] pos;
    } vec_t;

    vec_t       tbl [$];
    int         n_cmp  = 0;
    int         n_fail = 0;

    logic [7:0] cap [8];
    int         ncap;
    bit         saw_err, saw_done, gap, both, busy1, done_busy;
    int         first_idx;
    logic [2:0] pos_end;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [2:0] t, input logic [1:0] m);
        if (sel == 0) begin
            bus1.start = s; bus1.target = t; bus1.term = m;
        end else begin
            bus3.start = s; bus3.target = t; bus3.term = m;
        end
    endtask

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 0) o = '{bus1.code_out, bus1.code_valid, bus1.busy, bus1.done, bus1.err, bus1.pos};
        else          o = '{bus3.code_out, bus3.code_valid, bus3.busy, bus3.done, bus3.err, bus3.pos};
        return o;
    endfunction

    task automatic add(input int sel, input logic [2:0] tgt, input logic [1:0] trm, input bit e,
                       input int n, input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                       input logic [7:0] c3, input logic [7:0] c4, input logic [7:0] c5,
                       input logic [2:0] pos);
        vec_t v;
        v.sel = sel; v.tgt = tgt; v.trm = trm; v.exp_err = e; v.n = n;
        v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3; v.c[4] = c4; v.c[5] = c5;
        v.pos = pos;
        tbl.push_back(v);
    endtask

    // Issue one request and record the resulting stream until done or err.
    // inj_at > 0 pulses a second (ignored) start on that observation cycle.
    task automatic do_req(input int sel, input logic [2:0] tgt, input logic [1:0] trm, input int inj_at);
        obs_t o;
        bit   dropped;
        ncap = 0; saw_err = 0; saw_done = 0; gap = 0; both = 0; busy1 = 0; done_busy = 0;
        first_idx = -1; pos_end = 3'd0; dropped = 0;
        @(negedge clk);
        drive(sel, 1'b1, tgt, trm);
        @(negedge clk);
        drive(sel, 1'b0, tgt ^ 3'b111, trm ^ 2'b11);
        for (int idx = 1; idx <= 40; idx++) begin
            o = sample(sel);
            if (idx == 1) busy1 = o.busy;
            if (inj_at > 0 && idx == inj_at)       drive(sel, 1'b1, 3'd1, 2'd1);
            else if (inj_at > 0 && idx == inj_at + 1) drive(sel, 1'b0, 3'd0, 2'd0);
            if (o.valid) begin
                if (dropped) gap = 1;
                if (ncap < 8) cap[ncap] = o.code;
                ncap++;
                if (first_idx < 0) first_idx = idx;
            end else if (ncap > 0) begin
                dropped = 1;
            end
            if (o.err && o.done) both = 1;
            if (o.err) begin
                saw_err = 1; pos_end = o.pos; break;
            end
            if (o.done) begin
                saw_done = 1; pos_end = o.pos; done_busy = o.busy; break;
            end
            @(negedge clk);
        end
        drive(sel, 1'b0, 3'd0, 2'd0);
    endtask

    initial begin
        obs_t o;
        string nm;

        drive(0, 1'b0, 3'd0, 2'd0);
        drive(1, 1'b0, 3'd0, 2'd0);

        // Single-cycle-code instance: position carries over between entries.
        add(0, 3'd3, 2'd0, 0, 1, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd3);
        add(0, 3'd5, 2'd2, 0, 3, 8'hC7, 8'hBA, 8'h8D, 8'h00, 8'h00, 8'h00, 3'd0);
        add(0, 3'd3, 2'd0, 0, 1, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd3);
        add(0, 3'd1, 2'd1, 0, 3, 8'hA4, 8'h90, 8'h9E, 8'h00, 8'h00, 8'h00, 3'd0);
        add(0, 3'd4, 2'd1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
        add(0, 3'd2, 2'd2, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
        add(0, 3'd0, 2'd0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
        add(0, 3'd6, 2'd0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
        add(0, 3'd1, 2'd3, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
        add(0, 3'd4, 2'd0, 0, 1, 8'hC7, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd4);
        add(0, 3'd4, 2'd0, 0, 1, 8'hC7, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd4);
        add(0, 3'd1, 2'd0, 0, 3, 8'h82, 8'hA4, 8'h90, 8'h00, 8'h00, 8'h00, 3'd1);
        add(0, 3'd5, 2'd0, 0, 4, 8'hA4, 8'h82, 8'hC7, 8'hBA, 8'h00, 8'h00, 3'd5);
        add(0, 3'd7, 2'd0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd5);
        add(0, 3'd4, 2'd2, 0, 2, 8'hC7, 8'h8D, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
        add(0, 3'd2, 2'd1, 0, 2, 8'hA4, 8'h9E, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
        // Three-cycle-hold instance.
        add(1, 3'd2, 2'd0, 0, 3, 8'hA4, 8'hA4, 8'hA4, 8'h00, 8'h00, 8'h00, 3'd2);
        add(1, 3'd2, 2'd0, 0, 3, 8'hA4, 8'hA4, 8'hA4, 8'h00, 8'h00, 8'h00, 3'd2);
        add(1, 3'd3, 2'd1, 0, 6, 8'h82, 8'h82, 8'h82, 8'h9E, 8'h9E, 8'h9E, 3'd0);

        // Reset state of both instances.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            o = sample(s);
            chk($sformatf("rst%0d.code", s),  o.code,  8'hFF);
            chk($sformatf("rst%0d.valid", s), o.valid, 0);
            chk($sformatf("rst%0d.busy", s),  o.busy,  0);
            chk($sformatf("rst%0d.done", s),  o.done,  0);
            chk($sformatf("rst%0d.err", s),   o.err,   0);
            chk($sformatf("rst%0d.pos", s),   o.pos,   0);
        end
        rst = 1'b0;

        // Table-driven requests.
        foreach (tbl[i]) begin
            do_req(tbl[i].sel, tbl[i].tgt, tbl[i].trm, 0);
            nm = $sformatf("v%0d", i);
            chk({nm, ".ended"}, int'(saw_err | saw_done), 1);
            chk({nm, ".err"}, saw_err, tbl[i].exp_err);
            chk({nm, ".ncodes"}, ncap, tbl[i].n);
            chk({nm, ".pos"}, pos_end, tbl[i].pos);
            chk({nm, ".err_and_done"}, both, 0);
            if (tbl[i].exp_err) begin
                chk({nm, ".busy_on_err"}, busy1, 0);
            end else begin
                chk({nm, ".busy_entry"}, busy1, 1);
                chk({nm, ".latency"}, first_idx, 2);
                chk({nm, ".gap"}, gap, 0);
                chk({nm, ".busy_at_done"}, done_busy, 0);
                for (int k = 0; k < tbl[i].n && k < ncap; k++)
                    chk($sformatf("%s.code%0d", nm, k), cap[k], tbl[i].c[k]);
            end
            @(negedge clk);
            o = sample(tbl[i].sel);
            chk({nm, ".pulse_end"}, int'(o.err | o.done), 0);
        end

        // start pulsed while busy must not disturb the stream (pos 0 -> 2 -> walk to 5 + hour).
        do_req(0, 3'd2, 2'd0, 0);
        chk("inj.pre_pos", pos_end, 2);
        do_req(0, 3'd5, 2'd2, 3);
        chk("inj.done", saw_done, 1);
        chk("inj.err", saw_err, 0);
        chk("inj.ncodes", ncap, 4);
        if (ncap == 4) begin
            chk("inj.code0", cap[0], 8'h82);
            chk("inj.code1", cap[1], 8'hC7);
            chk("inj.code2", cap[2], 8'hBA);
            chk("inj.code3", cap[3], 8'h8D);
        end
        chk("inj.pos", pos_end, 0);
        @(negedge clk);
        o = sample(0);
        chk("inj.no_err_after", o.err, 0);

        // Reset during the second code of the 3 -> 5 + hour stream.
        do_req(0, 3'd3, 2'd0, 0);
        chk("rstmid.pre_pos", pos_end, 3);
        @(negedge clk);
        drive(0, 1'b1, 3'd5, 2'd2);
        @(negedge clk);
        drive(0, 1'b0, 3'd0, 2'd0);
        @(negedge clk);
        o = sample(0);
        chk("rstmid.code1", o.code, 8'hC7);
        @(negedge clk);
        o = sample(0);
        chk("rstmid.code2", o.code, 8'hBA);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        o = sample(0);
        chk("rstmid.code", o.code, 8'hFF);
        chk("rstmid.valid", o.valid, 0);
        chk("rstmid.busy", o.busy, 0);
        chk("rstmid.pos", o.pos, 0);
        chk("rstmid.done", o.done, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            o = sample(0);
            chk($sformatf("rstmid.quiet%0d", k), int'(o.done | o.valid | o.busy), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/code_seq_gen.md
Name: code_seq_gen

Overview:
Transmit-side companion to the 8-bit position-code decoder state machine. It generates the code stream that walks the decoder from its current position to a requested target position (1..5), then optionally appends a terminator code (action or hour). It enforces the decoder's legal-transition rules, so every emitted stream is accepted without reaching the error state. It sits between the command logic and the decoder's 8-bit code input.

Parameters:
C1, 8'h90, code for position 1
C2, 8'hA4, code for position 2
C3, 8'h82, code for position 3
C4, 8'hC7, code for position 4
C5, 8'hBA, code for position 5
C_ACT, 8'h9E, action terminator; legal only from positions 1..3
C_HOUR, 8'h8D, hour terminator; legal only from positions 4..5
IDLE_CODE, 8'hFF, value driven on code_out when no code is being emitted
STEP_CYCLES, 1, clk cycles each code is held (range 1..15)

Ports:
clk  in  1  clock; all logic is posedge
rst  in  1  reset; synchronous, active-high
start  in  1  request strobe; sampled only while busy=0
target  in  3  requested final position, legal range 1..5
term  in  2  terminator select: 0=none, 1=C_ACT, 2=C_HOUR, 3=illegal
code_out  out  8  code presented to the decoder
code_valid  out  1  high on every cycle that code_out carries a generated code
busy  out  1  sequence in progress
done  out  1  one-cycle pulse after the last code of a sequence
err  out  1  one-cycle pulse when a request is rejected
pos  out  3  tracked decoder position: 0=home/unknown, 1..5

Behaviour:
- Reset (rst=1 at a posedge): code_out=IDLE_CODE, code_valid=0, busy=0, done=0, err=0, pos=0, FSM to IDLE, hold counter=0. Reset wins over everything, including a sequence in progress. The downstream decoder must be reset together with this block.
- FSM states: IDLE, STEP, TERM, FIN.
- IDLE, start=1: validate the request in that same cycle.
  - Reject if target is 0, 6 or 7; if term=3; if term=1 and target>3; or if term=2 and target<4.
  - On reject: err=1 on the next cycle only; pos unchanged; no code is emitted; the FSM stays in IDLE.
  - On accept: latch target and term. On the next cycle, busy=1 and the FSM enters STEP.
- STEP: emit the code for the next position as follows.
  - If pos=0, the next position is target (direct jump, legal from home).
  - Else if pos<target, the next position is pos+1.
  - Else if pos>target, the next position is pos-1.
  - Else (pos=target) the next position is target, emitted once.
  - code_out=Cn and code_valid=1 for exactly STEP_CYCLES consecutive cycles. pos updates to the new position on the last hold cycle.
  - After a code, if the new position is not target, repeat STEP.
  - If the new position is target: go to TERM if term is nonzero, else go to FIN.
- Number of position codes emitted: 1 if pos=0 or pos=target; otherwise |target-pos|.
- TERM: emit C_ACT or C_HOUR for STEP_CYCLES cycles with code_valid=1, then go to FIN. pos becomes 0 on the last cycle, because the decoder has no exit from its terminator states except reset.
- FIN: busy=0, done=1, code_out=IDLE_CODE, code_valid=0 for one cycle, then IDLE. A start sampled in FIN is ignored.
- code_valid is high continuously across back-to-back codes, with no gap cycles between them.
- start while busy=1 is ignored: no err pulse and no effect on the sequence.
- target and term changes after acceptance have no effect.
- err and done are never high in the same cycle.
- The hold counter is 4 bits wide. It is cleared at the entry to each code and never wraps within a code.
- Latency: with STEP_CYCLES=1, the first code appears 2 cycles after the start edge, i.e. on the cycle after the busy=1 entry cycle.

Test Plan:
1. Reset, then start with target=3, term=0 (STEP_CYCLES=1) -> one code cycle of 8'h82 with valid=1; done pulse on the next cycle; pos=3; err stays 0.
2. From pos=3, start with target=5, term=2 -> 8'hC7, 8'hBA, 8'h8D on 3 consecutive valid cycles; then done; final pos=0.
3. From pos=3 (replay scenario 1 first), start with target=1, term=1 -> 8'hA4, 8'h90, 8'h9E consecutive; then done; pos=0.
4. Illegal requests from pos=0 -> each gives one err pulse, no code_valid, pos unchanged. Cases: target=4 with term=1; target=2 with term=2; target=0; target=6; term=3.
5. STEP_CYCLES=3, start from pos=0 with target=2, term=0 -> 8'hA4 held for 3 cycles with valid=1; then done. Repeating the same request from pos=2 -> 8'hA4 held 3 cycles again; pos stays 2.
6. Mid-sequence events:
   - start pulse while busy -> no change to the stream.
   - rst asserted on the 2nd code of scenario 2 -> next cycle code_out=8'hFF, valid=0, busy=0, pos=0, and no done pulse.
